gpu_host_loader: RTL

GPU_HOST_LOADER -- requirements
Module: gpu_host_loader

---
 rtl/gpu_host_loader.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/gpu_host_loader.sv
// =============================================================================
// Module      : gpu_host_loader
// Description : Host-side job sequencer for the GPU controller. Streams a
//               payload into GPU global memory, launches the kernel and
//               waits for the core to halt, with timeouts on each wait.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module gpu_host_loader #(
    parameter int data_width  = 32,
    parameter int ACK_TIMEOUT = 1023,
    parameter int RUN_TIMEOUT = 65535
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [data_width-1:0] load_addr,
    input  logic [15:0]           load_count,
    input  logic [data_width-1:0] launch_pc,
    input  logic                  s_valid,
    input  logic [data_width-1:0] s_data,
    output logic                  s_ready,
    output logic [31:0]           cpu_recv_instr,
    output logic [data_width-1:0] cpu_in_data,
    input  logic [data_width-1:0] cpu_out_data,
    input  logic                  cpu_out_ack,
    input  logic                  gpu_halt,
    output logic                  busy,
    output logic                  done,
    output logic [1:0]            error,
    output logic [data_width-1:0] result
);

    localparam logic [2:0] c_st_idle        = 3'd0;
    localparam logic [2:0] c_st_copy_cmd    = 3'd1;
    localparam logic [2:0] c_st_copy_arg    = 3'd2;
    localparam logic [2:0] c_st_copy_data   = 3'd3;
    localparam logic [2:0] c_st_copy_wait   = 3'd4;
    localparam logic [2:0] c_st_launch      = 3'd5;
    localparam logic [2:0] c_st_launch_wait = 3'd6;
    localparam logic [2:0] c_st_run_wait    = 3'd7;

    localparam logic [31:0] c_op_nop    = 32'd0;
    localparam logic [31:0] c_op_copy   = 32'd1;
    localparam logic [31:0] c_op_arg    = 32'd2;
    localparam logic [31:0] c_op_launch = 32'd3;
    localparam logic [31:0] c_op_word   = 32'd4;

    localparam logic [31:0] c_ack_limit = 32'(ACK_TIMEOUT);
    localparam logic [31:0] c_run_limit = 32'(RUN_TIMEOUT);

    logic [2:0]            r_state;
    logic [data_width-1:0] r_addr;
    logic [15:0]           r_count;
    logic [15:0]           r_remaining;
    logic [data_width-1:0] r_pc;
    logic [31:0]           r_timer;
    logic                  r_done;
    logic [1:0]            r_error;
    logic [data_width-1:0] r_result;

    logic [31:0]           w_instr;
    logic [data_width-1:0] w_data;
    logic                  w_xfer;

    assign w_xfer = (r_state == c_st_copy_data) && s_valid;

    // Command bus is a pure decode of the state so WORD can pass s_data through
    // in the handshake cycle; every other cycle reads as NOP with zero data.
    always_comb begin
        w_instr = c_op_nop;
        w_data  = '0;
        case (r_state)
            c_st_copy_cmd: begin
                w_instr = c_op_copy;
                w_data  = r_addr;
            end
            c_st_copy_arg: begin
                w_instr = c_op_arg;
                w_data  = data_width'(r_count);
            end
            c_st_copy_data: begin
                if (s_valid) begin
                    w_instr = c_op_word;
                    w_data  = s_data;
                end
            end
            c_st_launch: begin
                w_instr = c_op_launch;
                w_data  = r_pc;
            end
            default: begin
                w_instr = c_op_nop;
                w_data  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= c_st_idle;
            r_addr      <= '0;
            r_count     <= '0;
            r_remaining <= '0;
            r_pc        <= '0;
            r_timer     <= '0;
            r_done      <= 1'b0;
            r_error     <= 2'd0;
            r_result    <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (start) begin
                        r_addr      <= load_addr;
                        r_count     <= load_count;
                        r_remaining <= load_count;
                        r_pc        <= launch_pc;
                        r_error     <= 2'd0;
                        r_state     <= (load_count != 16'd0) ? c_st_copy_cmd : c_st_launch;
                    end
                end
                c_st_copy_cmd: r_state <= c_st_copy_arg;
                c_st_copy_arg: r_state <= c_st_copy_data;
                c_st_copy_data: begin
                    if (w_xfer) begin
                        r_remaining <= r_remaining - 16'd1;
                        if (r_remaining == 16'd1) begin
                            r_timer <= '0;
                            r_state <= c_st_copy_wait;
                        end
                    end
                end
                c_st_copy_wait: begin
                    // An ack arriving on the limit cycle still counts as success.
                    if (cpu_out_ack) begin
                        r_state <= c_st_launch;
                    end else if (r_timer == c_ack_limit) begin
                        r_error <= 2'd1;
                        r_state <= c_st_idle;
                    end else begin
                        r_timer <= r_timer + 32'd1;
                    end
                end
                c_st_launch: begin
                    r_timer <= '0;
                    r_state <= c_st_launch_wait;
                end
                c_st_launch_wait: begin
                    if (cpu_out_ack) begin
                        r_result <= cpu_out_data;
                        r_timer  <= '0;
                        r_state  <= c_st_run_wait;
                    end else if (r_timer == c_ack_limit) begin
                        r_error <= 2'd1;
                        r_state <= c_st_idle;
                    end else begin
                        r_timer <= r_timer + 32'd1;
                    end
                end
                c_st_run_wait: begin
                    if (gpu_halt) begin
                        r_done  <= 1'b1;
                        r_state <= c_st_idle;
                    end else if (r_timer == c_run_limit) begin
                        r_error <= 2'd2;
                        r_state <= c_st_idle;
                    end else begin
                        r_timer <= r_timer + 32'd1;
                    end
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

    assign s_ready        = (r_state == c_st_copy_data);
    assign busy           = (r_state != c_st_idle);
    assign cpu_recv_instr = w_instr;
    assign cpu_in_data    = w_data;
    assign done           = r_done;
    assign error          = r_error;
    assign result         = r_result;

endmodule

`default_nettype wire
